// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loader_pkg - shared state encoding and framing constants for loader   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } loader_state_e;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | byte_packer - little-endian lane counter and word assembler for imem_loader |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    localparam int LW = $clog2(BYTES_PER_WORD);

    logic [LW-1:0]               r_lane;
    logic [8*BYTES_PER_WORD-1:0] r_word;

    assign o_word_done = i_en && (r_lane == LW'(BYTES_PER_WORD - 1));
    assign o_word      = r_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (i_clr) begin
            r_lane <= '0;
        end else if (i_en) begin
            r_word[8*r_lane +: 8] <= i_byte;
            r_lane <= o_word_done ? '0 : r_lane + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loader - byte stream to imem writer, holds core in reset (opt macro:  |
// | IMEM_LOADER_CHECKSUM_EN adds trailing XOR checksum byte)  Revision: 1.0    |
// +----------------------------------------------------------------------------+
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int N = 2048
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic        o_we,
    output logic [31:0] o_waddr,
    output logic [31:0] o_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_cpu_rst_n
);

    localparam int IW = $clog2(N) + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_e S_AFTER_DATA = CSUM;
`else
    localparam loader_state_e S_AFTER_DATA = DONE;
`endif

    loader_state_e r_state;
    logic [15:0]   r_word_cnt;
    logic          r_len_idx;
    logic [IW-1:0] r_idx;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    r_csum;
`endif

    logic          w_xfer;
    logic          w_start_ok;
    logic          w_word_done;
    logic [15:0]   w_len;
    logic [31:0]   w_word;

    assign w_xfer     = i_rx_valid && o_rx_ready;
    assign w_start_ok = i_start && (r_state == IDLE || r_state == DONE || r_state == ERR);
    assign w_len      = {i_rx_data, r_word_cnt[7:0]};

    byte_packer u_packer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clr       (w_start_ok),
        .i_en        (w_xfer && (r_state == DATA)),
        .i_byte      (i_rx_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_word_cnt <= '0;
            r_len_idx  <= 1'b0;
            r_idx      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (i_start) begin
                        r_state   <= LEN;
                        r_len_idx <= 1'b0;
                        r_idx     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum    <= '0;
`endif
                    end
                end
                LEN: begin
                    if (w_xfer) begin
                        if (r_len_idx == 1'(LEN_BYTES - 1)) begin
                            r_word_cnt[15:8] <= i_rx_data;
                            if (w_len == 16'd0)
                                r_state <= S_AFTER_DATA;
                            else if (32'(w_len) > N)
                                r_state <= ERR;
                            else
                                r_state <= DATA;
                        end else begin
                            r_word_cnt[7:0] <= i_rx_data;
                            r_len_idx       <= r_len_idx + 1'b1;
                        end
                    end
                end
                DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (w_xfer)
                        r_csum <= r_csum ^ i_rx_data;
`endif
                    if (w_word_done)
                        r_state <= WRITE;
                end
                WRITE: begin
                    r_idx <= r_idx + 1'b1;
                    // idx cannot exceed N because the length check rejected word_cnt > N
                    if (32'(r_idx) + 32'd1 == 32'(r_word_cnt))
                        r_state <= S_AFTER_DATA;
                    else
                        r_state <= DATA;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (w_xfer)
                        r_state <= (i_rx_data == r_csum) ? DONE : ERR;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_rx_ready  = (r_state == LEN) || (r_state == DATA) || (r_state == CSUM);
    assign o_busy      = (r_state == LEN) || (r_state == DATA) || (r_state == WRITE) ||
                         (r_state == CSUM);
    assign o_we        = (r_state == WRITE);
    assign o_waddr     = 32'({r_idx, 2'b00});
    assign o_wdata     = w_word;
    assign o_done      = (r_state == DONE);
    assign o_err       = (r_state == ERR);
    assign o_cpu_rst_n = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imem_loader - self-checking bench for imem_loader                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_imem_loader;

    localparam int N = 2048;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_ready, we, busy, done, err, cpu_rst_n;
    logic [31:0] waddr, wdata;

    always #5 clk = ~clk;

    imem_loader #(.N(N)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_rx_ready  (rx_ready),
        .o_we        (we),
        .o_waddr     (waddr),
        .o_wdata     (wdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_cpu_rst_n (cpu_rst_n)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] len;
        bit          bad_csum;
        int          gap;
        bit          start_mid;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    logic [7:0] tx_q[$];
    wr_t        exp_q[$];
    int         m_ndata;
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] xor_data();
        logic [7:0] cs = 8'h00;
        for (int k = 2; k < tx_q.size(); k++) cs ^= tx_q[k];
        return cs;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, 32'(rx_ready), 0);
        chk({tag, "_we"}, 32'(we), 0);
        chk({tag, "_waddr"}, waddr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 0);
    endtask

    // Reference: a session is len bytes, then len words of 4 LE bytes (only if len <= N)
    task automatic build_random(input logic [15:0] len);
        logic [31:0] word;
        tx_q.delete();
        exp_q.delete();
        tx_q.push_back(len[7:0]);
        tx_q.push_back(len[15:8]);
        m_ndata = (int'(len) <= N) ? int'(len) * 4 : 0;
        for (int w = 0; w < m_ndata / 4; w++) begin
            word = $urandom();
            for (int k = 0; k < 4; k++) tx_q.push_back(word[8*k +: 8]);
            exp_q.push_back('{32'(w * 4), word});
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (int'(len) <= N) tx_q.push_back(xor_data());
`endif
    endtask

    task automatic monitor(input bit exp_we, input bit in_stream);
        wr_t e;
        chk("we_timing", 32'(we), 32'(exp_we));
        if (we) begin
            chk("ready_in_write", 32'(rx_ready), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write_cnt", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                chk("waddr", waddr, e.addr);
                chk("wdata", wdata, e.data);
            end
        end else if (in_stream) begin
            chk("ready_in_stream", 32'(rx_ready), 1);
        end
    endtask

    task automatic stream(input int gap, input bit start_mid);
        int i = 0;
        int cyc = 0;
        int budget = 20 * tx_q.size() + 50;
        bit prev_wc = 1'b0;
        bit xfer;
        bit mid_done = 1'b0;
        while (i < tx_q.size()) begin
            if (cyc >= budget) begin
                chk("stream_timeout_bytes", 32'(i), 32'(tx_q.size()));
                break;
            end
            rx_valid = ($urandom_range(99) >= gap);
            rx_data  = tx_q[i];
            start    = start_mid && (i == 5) && !mid_done;
            if (start) mid_done = 1'b1;
            @(negedge clk);
            monitor(prev_wc, 1'b1);
            xfer    = rx_valid && rx_ready;
            prev_wc = xfer && (i >= 2) && (i - 2 < m_ndata) && ((i - 2) % 4 == 3);
            @(posedge clk);
            #1;
            if (xfer) i++;
            cyc++;
        end
        rx_valid = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        monitor(prev_wc, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_session(input int gap, input bit start_mid, input bit exp_done, input bit exp_err);
        start    = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_busy", 32'(busy), 1);
        chk("start_cpu_rst_n", 32'(cpu_rst_n), 0);
        chk("start_done", 32'(done), 0);
        chk("start_err", 32'(err), 0);
        @(posedge clk);
        #1;
        stream(gap, start_mid);
        @(negedge clk);
        chk("end_done", 32'(done), 32'(exp_done));
        chk("end_err", 32'(err), 32'(exp_err));
        chk("end_cpu_rst_n", 32'(cpu_rst_n), 32'(exp_done));
        chk("end_busy", 32'(busy), 0);
        chk("end_ready", 32'(rx_ready), 0);
        chk("end_we", 32'(we), 0);
        chk("writes_missing", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[$];
        vecs.push_back('{16'd0,      1'b0, 0,  1'b0, 1'b1, 1'b0});
        vecs.push_back('{16'h0801,   1'b0, 0,  1'b0, 1'b0, 1'b1});
        vecs.push_back('{16'd1,      1'b0, 0,  1'b0, 1'b1, 1'b0});
        vecs.push_back('{16'hFFFF,   1'b0, 10, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{16'd5,      1'b0, 40, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{16'd12,     1'b0, 70, 1'b0, 1'b1, 1'b0});
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs.push_back('{16'd3,      1'b1, 20, 1'b1, 1'b0, 1'b1});
`endif
        vecs.push_back('{16'd4,      1'b0, 25, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{16'd2048,   1'b0, 0,  1'b0, 1'b1, 1'b0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("idle");
        @(posedge clk);
        #1;

        tx_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        exp_q = '{'{32'h0, 32'h00A00513}, '{32'h4, 32'h0000006F}};
        m_ndata = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
        tx_q.push_back(xor_data());
`endif
        do_session(0, 1'b0, 1'b1, 1'b0);

        for (int v = 0; v < vecs.size(); v++) begin
            build_random(vecs[v].len);
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (vecs[v].bad_csum) tx_q[tx_q.size() - 1] ^= 8'hA5;
`endif
            do_session(vecs[v].gap, vecs[v].start_mid, vecs[v].exp_done, vecs[v].exp_err);
        end

        // Abort after 5 data bytes: one word already written, then async reset mid-cycle
        build_random(16'd3);
        while (tx_q.size() > 7) void'(tx_q.pop_back());
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stream(30, 1'b0);
        chk("abort_words_written", 32'(exp_q.size()), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("abort");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        build_random(16'd2);
        do_session(15, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
